// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and helper functions for the round-robin arbiter
// Purpose : default parameter values, a constant-evaluable clog2 and a one-hot to index encoder.
// Ports   : none (package).
package rr_arb_pkg;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_MAX_BURST = 1;

   // Widest one-hot vector onehot_to_idx accepts; callers zero-extend into it.
   localparam int MAX_CH = 32;

   // Never returns less than 1 so derived widths stay legal for tiny values.
   function automatic int clog2_f(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // OR of the set bit positions; exact for a one-hot or all-zero input.
   function automatic int onehot_to_idx(input logic [MAX_CH-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter_pipe_param_if.sv
// rtl/rr_arbiter_pipe_param_if.sv - channel-side and consumer-side handshake bundle
// Purpose : groups the per-channel request bus and the single output stream.
// Ports   : in_data/in_valid/ch_enable/out_ready driven by the environment (master),
//           in_ready/out_data/out_ch/out_valid driven by the arbiter (slave).
interface rr_arbiter_pipe_param_if
   import rr_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DATA_W = DEF_DATA_W,
   localparam int CH_W  = clog2_f(NUM_CH)
);
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH-1:0]        ch_enable;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_ch;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output in_data, in_valid, ch_enable, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, ch_enable, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder
// Purpose : grants the first requester found searching upward from ptr+1 with wrap.
// Ports   : req_i request vector, ptr_i last-served index,
//           gnt_o one-hot grant (zero when no request), gnt_idx_o grant index.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   localparam int CH_W  = clog2_f(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   gnt_idx_o
);

   logic [CH_W:0]          shamt;
   logic [2*NUM_CH-1:0]    dbl;
   logic [NUM_CH-1:0]      rot;
   logic [NUM_CH-1:0]      first;
   logic [2*NUM_CH-1:0]    back;

   // Rotate so bit 0 is channel ptr+1, isolate the lowest set bit, rotate back.
   // The doubled vector makes the wrap-around free of modulo arithmetic.
   assign shamt = {1'b0, ptr_i} + (CH_W+1)'(1);
   assign dbl   = {req_i, req_i} >> shamt;
   assign rot   = dbl[NUM_CH-1:0];
   assign first = rot & (~rot + NUM_CH'(1));
   assign back  = {{NUM_CH{1'b0}}, first} << shamt;

   assign gnt_o     = back[NUM_CH-1:0] | back[2*NUM_CH-1:NUM_CH];
   assign gnt_idx_o = CH_W'(onehot_to_idx(MAX_CH'(gnt_o)));

endmodule

// File: rtl/rr_arbiter_pipe_param.sv
// rtl/rr_arbiter_pipe_param.sv - round-robin arbiter/mux with burst hold and one output register
// Purpose : selects one eligible channel per cycle (holding the owner for up to MAX_BURST
//           beats), registers its data and index, and honours downstream backpressure.
// Ports   : clk rising-edge clock, rst asynchronous active-low reset,
//           bus slave view of rr_arbiter_pipe_param_if.
module rr_arbiter_pipe_param
   import rr_arb_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST,
   localparam int CH_W     = clog2_f(NUM_CH)
) (
   input logic                     clk,
   input logic                     rst,
   rr_arbiter_pipe_param_if.slave  bus
);

   localparam int BW = clog2_f(MAX_BURST + 1);

   logic [DATA_W-1:0] out_data_q;
   logic [CH_W-1:0]   out_ch_q;
   logic              out_valid_q;
   logic [CH_W-1:0]   ptr_q;
   logic [CH_W-1:0]   owner_q;
   logic [BW-1:0]     burst_cnt_q;

   logic              load_en;
   logic              hold;
   logic              xfer;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] pick_gnt;
   logic [CH_W-1:0]   pick_idx;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .req_i     (eligible),
      .ptr_i     (ptr_q),
      .gnt_o     (pick_gnt),
      .gnt_idx_o (pick_idx)
   );

   assign load_en  = !out_valid_q || bus.out_ready;
   assign eligible = bus.in_valid & bus.ch_enable;

   // burst_cnt_q == 0 marks "no live burst" (after reset or an idle load), forcing rotation.
   assign hold = (burst_cnt_q != '0) && (burst_cnt_q < BW'(MAX_BURST)) && eligible[owner_q];

   assign gnt     = hold ? (NUM_CH'(1) << owner_q) : pick_gnt;
   assign gnt_idx = hold ? owner_q : pick_idx;
   assign xfer    = load_en && (gnt != '0);

   // Gated by rst so the accept drops the instant reset asserts, not at the next edge.
   assign bus.in_ready  = (rst && load_en) ? gnt : '0;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= CH_W'(NUM_CH - 1);
         owner_q     <= '0;
         burst_cnt_q <= '0;
      end else if (load_en) begin
         if (xfer) begin
            out_data_q  <= bus.in_data[gnt_idx*DATA_W +: DATA_W];
            out_ch_q    <= gnt_idx;
            out_valid_q <= 1'b1;
            ptr_q       <= gnt_idx;
            owner_q     <= gnt_idx;
            burst_cnt_q <= hold ? burst_cnt_q + BW'(1) : BW'(1);
         end else begin
            out_valid_q <= 1'b0;
            burst_cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter_pipe_param.sv
// tb/tb_rr_arbiter_pipe_param.sv - randomized model-checked bench for rr_arbiter_pipe_param
module tb_rr_arbiter_pipe_param;
   import rr_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din [N];
   logic [3:0] vld;
   logic [3:0] ena;
   logic       ordy;

   int n_checks = 0;
   int n_errors = 0;

   // index 0: MAX_BURST=1, index 1: MAX_BURST=3
   int         mbv [2] = '{1, 3};
   logic       m_valid [2];
   logic [7:0] m_data [2];
   logic [1:0] m_ch [2];
   int         m_last [2];
   int         m_run [2];

   rr_arbiter_pipe_param_if #(.NUM_CH(N), .DATA_W(W)) if1 ();
   rr_arbiter_pipe_param_if #(.NUM_CH(N), .DATA_W(W)) if3 ();

   assign if1.in_data   = {din[3], din[2], din[1], din[0]};
   assign if1.in_valid  = vld;
   assign if1.ch_enable = ena;
   assign if1.out_ready = ordy;
   assign if3.in_data   = {din[3], din[2], din[1], din[0]};
   assign if3.in_valid  = vld;
   assign if3.ch_enable = ena;
   assign if3.out_ready = ordy;

   rr_arbiter_pipe_param #(.NUM_CH(N), .DATA_W(W), .MAX_BURST(1)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );
   rr_arbiter_pipe_param #(.NUM_CH(N), .DATA_W(W), .MAX_BURST(3)) dut3 (
      .clk (clk), .rst (rst), .bus (if3.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = 8'd0;
         m_ch[k]    = 2'd0;
         m_last[k]  = N - 1;
         m_run[k]   = 0;
      end
   endtask

   // Winner by the arbitration rules: keep the owner while its quota lasts, else the
   // first eligible channel after the last winner, wrapping around.
   function automatic int pick(input int mb, input int last, input int run, input logic [3:0] el);
      int c;
      c = last;
      if (run > 0 && run < mb && el[c[1:0]]) return last;
      for (int k = 1; k <= N; k++) begin
         c = (last + k) % N;
         if (el[c[1:0]]) return c;
      end
      return -1;
   endfunction

   // Checks the combinational accept and the registered outputs, then advances the model
   // across one rising edge. Called shortly after inputs change on the falling edge.
   task automatic cycle();
      logic [3:0] el;
      logic [3:0] exp_rdy;
      logic [3:0] obs_rdy;
      logic       obs_v;
      logic [7:0] obs_d;
      logic [1:0] obs_c;
      logic       ld;
      logic       held;
      int         g;
      int         lst;
      logic       n_valid [2];
      logic [7:0] n_data [2];
      logic [1:0] n_ch [2];
      int         n_last [2];
      int         n_run [2];
      #1;
      el = vld & ena;
      for (int k = 0; k < 2; k++) begin
         obs_rdy = (k == 0) ? if1.in_ready  : if3.in_ready;
         obs_v   = (k == 0) ? if1.out_valid : if3.out_valid;
         obs_d   = (k == 0) ? if1.out_data  : if3.out_data;
         obs_c   = (k == 0) ? if1.out_ch    : if3.out_ch;
         ld      = !m_valid[k] || ordy;
         lst     = m_last[k];
         g       = pick(mbv[k], m_last[k], m_run[k], el);
         held    = m_run[k] > 0 && m_run[k] < mbv[k] && el[lst[1:0]];
         exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
         chk($sformatf("mb%0d_in_ready", mbv[k]), 32'(obs_rdy), 32'(exp_rdy));
         chk($sformatf("mb%0d_out_valid", mbv[k]), 32'(obs_v), 32'(m_valid[k]));
         chk($sformatf("mb%0d_out_data", mbv[k]), 32'(obs_d), 32'(m_data[k]));
         chk($sformatf("mb%0d_out_ch", mbv[k]), 32'(obs_c), 32'(m_ch[k]));
         n_valid[k] = m_valid[k];
         n_data[k]  = m_data[k];
         n_ch[k]    = m_ch[k];
         n_last[k]  = m_last[k];
         n_run[k]   = m_run[k];
         if (ld) begin
            if (g >= 0) begin
               n_valid[k] = 1'b1;
               n_data[k]  = din[g];
               n_ch[k]    = 2'(g);
               n_last[k]  = g;
               n_run[k]   = held ? m_run[k] + 1 : 1;
            end else begin
               n_valid[k] = 1'b0;
               n_run[k]   = 0;
            end
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = n_valid[k];
         m_data[k]  = n_data[k];
         m_ch[k]    = n_ch[k];
         m_last[k]  = n_last[k];
         m_run[k]   = n_run[k];
      end
   endtask

   initial begin
      logic [7:0] rr_data [4];
      rr_data = '{8'd10, 8'd26, 8'd14, 8'd9};
      din  = rr_data;
      vld  = 4'b1111;
      ena  = 4'b1111;
      ordy = 1'b1;
      reset_model();

      // Held in reset across a few edges: outputs at reset values, no accepts.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
      chk("rst_out_data", 32'(if1.out_data), 32'd0);
      chk("rst_out_ch", 32'(if1.out_ch), 32'd0);
      chk("rst_in_ready", 32'(if1.in_ready), 32'd0);
      chk("rst_in_ready_mb3", 32'(if3.in_ready), 32'd0);

      // Pure round robin from channel 0 with the reference data set.
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         cycle();
         #1;
         chk("rr_out_ch", 32'(if1.out_ch), 32'(i % 4));
         chk("rr_out_data", 32'(if1.out_data), 32'(rr_data[i % 4]));
      end

      // Directed backpressure then randomized blocks of distinct traffic shapes.
      for (int blk = 0; blk < 7; blk++) begin
         for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) din[i] = 8'($urandom);
            case (blk)
               0: begin vld = 4'b1111; ena = 4'b1111; ordy = (c % 6) < 2; end
               1: begin vld = 4'b1111; ena = 4'b1010; ordy = 1'b1; end
               2: begin vld = 4'b0110; ena = 4'b1111; ordy = 1'b1; end
               3: begin vld = (c < 50) ? 4'b0010 : 4'b1000; ena = 4'b1111; ordy = 1'b1; end
               4: begin
                  vld  = 4'($urandom);
                  ena  = 4'b1111;
                  ordy = ($urandom_range(0, 3) != 0);
               end
               5: begin
                  vld  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                  ena  = 4'($urandom) | 4'b0101;
                  ordy = ($urandom_range(0, 1) != 0);
               end
               default: begin
                  vld  = 4'($urandom) | 4'($urandom);
                  ena  = 4'($urandom) | 4'($urandom);
                  ordy = ($urandom_range(0, 4) != 0);
               end
            endcase
            cycle();
         end
      end

      // Reset asserted between edges while streaming: outputs must drop without a clock.
      @(negedge clk);
      vld  = 4'b1111;
      ena  = 4'b1111;
      ordy = 1'b1;
      cycle();
      @(negedge clk);
      cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(if1.out_valid), 32'd0);
      chk("arst_in_ready", 32'(if1.in_ready), 32'd0);
      chk("arst_out_valid_mb3", 32'(if3.out_valid), 32'd0);
      chk("arst_in_ready_mb3", 32'(if3.in_ready), 32'd0);
      reset_model();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         cycle();
         #1;
         chk("arst_restart_ch", 32'(if1.out_ch), 32'(i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
